ssd_frame_scanner: RTL and testbench



---
 rtl/ssd_frame_scanner.sv | 159 +++++++++++++++
 tb/tb_ssd_frame_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_frame_scanner.sv
// ssd_frame_scanner: four-digit seven-segment scanner for the Nexys-4.
// Time-multiplexes An3..An0, PWM-dims the lit anode, and double-buffers
// display updates so the visible value only changes at a frame boundary.
// Optional build macro: SSD_LZ_BLANK_EN blanks leading zero digits
// (the rightmost digit is never blanked).
//
// Update strobe: load is a single-cycle request with no back-pressure; the
// block always accepts it. digits_in/dp_in are sampled on the cycle load is
// high, and the latest request before a frame boundary is the one shown.
module ssd_frame_scanner #(
    parameter int SCAN_DIV_W = 18,
    parameter int PWM_W      = 3
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic [15:0]      digits_in,
    input  logic [3:0]       dp_in,
    input  logic             load,
    input  logic [PWM_W-1:0] bright,
    output logic [3:0]       an,
    output logic [7:0]       cathodes,
    output logic             pending,
    output logic             frame_done
);

    // Per-digit prescaler and digit index (0 = An3 ... 3 = An0)
    logic [SCAN_DIV_W-1:0] cnt;
    logic [1:0]            idx;

    // Display values packed as {hex[15:0], dp[3:0]}
    logic [19:0]           act_val;
    logic [19:0]           pend_val;

    logic                  scan_wrap;
    logic                  boundary;
    logic [PWM_W-1:0]      pwm_phase;
    logic                  pwm_on;

    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic [3:0]            blank_mask;
    logic                  sel_blank;
    logic [6:0]            seg;
    logic [3:0]            an_next;
    logic [7:0]            cath_next;

    assign scan_wrap = &cnt;
    assign boundary  = scan_wrap && (idx == 2'd3);

    // PWM phase is the top bits of the prescaler, so each digit slot is
    // split into 2^PWM_W equal brightness steps.
    assign pwm_phase = cnt[SCAN_DIV_W-1 -: PWM_W];
    assign pwm_on    = (pwm_phase <= bright);

    // Prescaler and digit index advance
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= cnt + 1'b1;
            if (scan_wrap) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Double buffer: a load outside the boundary parks in pend_val; at the
    // boundary a same-cycle load wins over the parked value so it is not lost.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            act_val    <= '0;
            pend_val   <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (boundary) begin
                if (load) begin
                    act_val    <= {digits_in, dp_in};
                    pending    <= 1'b0;
                    frame_done <= 1'b1;
                end else if (pending) begin
                    act_val    <= pend_val;
                    pending    <= 1'b0;
                    frame_done <= 1'b1;
                end
            end else if (load) begin
                pend_val <= {digits_in, dp_in};
                pending  <= 1'b1;
            end
        end
    end

    // Select the nibble and decimal point for the digit being scanned
    always_comb begin
        sel_nib = act_val[19:16];
        sel_dp  = act_val[3];
        case (idx)
            2'd0: begin sel_nib = act_val[19:16]; sel_dp = act_val[3]; end
            2'd1: begin sel_nib = act_val[15:12]; sel_dp = act_val[2]; end
            2'd2: begin sel_nib = act_val[11:8];  sel_dp = act_val[1]; end
            default: begin sel_nib = act_val[7:4]; sel_dp = act_val[0]; end
        endcase
    end

    // Leading-zero mask, left to right; the rightmost digit always shows
    always_comb begin
        blank_mask = 4'b0000;
`ifdef SSD_LZ_BLANK_EN
        blank_mask[0] = (act_val[19:16] == 4'h0);
        blank_mask[1] = blank_mask[0] && (act_val[15:12] == 4'h0);
        blank_mask[2] = blank_mask[1] && (act_val[11:8] == 4'h0);
        blank_mask[3] = 1'b0;
`endif
        sel_blank = blank_mask[idx];
    end

    // Hex to active-low abcdefg
    always_comb begin
        seg = 7'b1111111;
        case (sel_nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

    // Next anode/cathode pattern; cathodes ignore PWM, only the anode dims
    always_comb begin
        an_next   = pwm_on ? ~(4'b1000 >> idx) : 4'b1111;
        cath_next = {(sel_blank ? 7'b1111111 : seg), ~sel_dp};
    end

    // Registered pin drivers, one cycle behind the scan state
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            an       <= 4'b1111;
            cathodes <= 8'hFF;
        end else begin
            an       <= an_next;
            cathodes <= cath_next;
        end
    end

endmodule

// File: tb/tb_ssd_frame_scanner.sv
// Directed bench for ssd_frame_scanner with SCAN_DIV_W=4, PWM_W=3.
// One frame is 64 clocks; frame boundaries fall on every 64th edge after
// reset release. Outputs are sampled 1 time unit after each rising edge.
module tb_ssd_frame_scanner;

    localparam int SCAN_DIV_W = 4;
    localparam int PWM_W      = 3;

    logic             board_clk;
    logic             Reset;
    logic [15:0]      digits_in;
    logic [3:0]       dp_in;
    logic             load;
    logic [PWM_W-1:0] bright;
    logic [3:0]       an;
    logic [7:0]       cathodes;
    logic             pending;
    logic             frame_done;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int fd_seen    = 0;
    int low_cycles = 0;

    logic [7:0] exp_cath [4];

    ssd_frame_scanner #(
        .SCAN_DIV_W(SCAN_DIV_W),
        .PWM_W     (PWM_W)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .load      (load),
        .bright    (bright),
        .an        (an),
        .cathodes  (cathodes),
        .pending   (pending),
        .frame_done(frame_done)
    );

    // Clock generation
    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected anode after edge n: digit slot and PWM phase of cycle n-1
    function automatic logic [3:0] exp_an(input int n, input logic [PWM_W-1:0] br);
        int d;
        int p;
        logic [3:0] onehot;
        d      = ((n - 1) / 16) % 4;
        p      = ((n - 1) % 16) / 2;
        onehot = 4'b1000 >> d;
        return (p <= int'(br)) ? ~onehot : 4'b1111;
    endfunction

    task automatic set_exp(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        exp_cath[0] = c0;
        exp_cath[1] = c1;
        exp_cath[2] = c2;
        exp_cath[3] = c3;
    endtask

    // Advance n clocks, checking scanned anode and cathodes every cycle
    task automatic run_cycles(input int n);
        int d;
        for (int i = 0; i < n; i++) begin
            @(posedge board_clk);
            #1;
            cyc++;
            d = ((cyc - 1) / 16) % 4;
            check_val("an", {28'd0, an}, {28'd0, exp_an(cyc, bright)});
            check_val("cathodes", {24'd0, cathodes}, {24'd0, exp_cath[d]});
            if (frame_done) fd_seen++;
            if (an != 4'b1111) low_cycles++;
        end
    endtask

    // One-cycle load strobe, captured on the next rising edge
    task automatic drive_load(input logic [15:0] val, input logic [3:0] dp);
        load      = 1'b1;
        digits_in = val;
        dp_in     = dp;
        run_cycles(1);
        load      = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        bright    = 3'd7;
        set_exp(8'h03, 8'h03, 8'h03, 8'h03);

        repeat (3) @(posedge board_clk);
        #1;
        check_val("rst_an", {28'd0, an}, 32'hF);
        check_val("rst_cath", {24'd0, cathodes}, 32'hFF);
        check_val("rst_pending", {31'd0, pending}, 32'd0);
        check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Idle frame: "0000", no update at the boundary
        Reset = 1'b0;
        cyc   = 0;
        run_cycles(63);
        check_val("idle_pending", {31'd0, pending}, 32'd0);
        run_cycles(1);
        check_val("idle_boundary_fd", {31'd0, frame_done}, 32'd0);
        check_val("idle_fd_count", fd_seen, 0);

        // Mid-frame load of 12AF with An0 decimal point
        run_cycles(15);
        drive_load(16'h12AF, 4'b0001);
        check_val("load_pending", {31'd0, pending}, 32'd1);
        check_val("load_no_fd", {31'd0, frame_done}, 32'd0);
        run_cycles(47);
        check_val("load_pending_held", {31'd0, pending}, 32'd1);
        check_val("load_fd_before_boundary", fd_seen, 0);
        run_cycles(1);
        check_val("load_fd_pulse", {31'd0, frame_done}, 32'd1);
        check_val("load_pending_clear", {31'd0, pending}, 32'd0);
        set_exp(8'b10011111, 8'b00100101, 8'b00010001, 8'b01110000);
        run_cycles(64);
        check_val("load_fd_count", fd_seen, 1);

        // Two loads in one frame: last one wins, one pulse
        fd_seen = 0;
        run_cycles(7);
        drive_load(16'h1111, 4'b0000);
        run_cycles(9);
        drive_load(16'h2222, 4'b0000);
        check_val("dbl_pending", {31'd0, pending}, 32'd1);
        run_cycles(45);
        run_cycles(1);
        check_val("dbl_fd_pulse", {31'd0, frame_done}, 32'd1);
        set_exp(8'b00100101, 8'b00100101, 8'b00100101, 8'b00100101);
        run_cycles(64);
        check_val("dbl_fd_count", fd_seen, 1);

        // Load landing exactly on the boundary cycle
        fd_seen = 0;
        run_cycles(63);
        drive_load(16'h00C3, 4'b0000);
        check_val("bnd_fd_pulse", {31'd0, frame_done}, 32'd1);
        check_val("bnd_pending", {31'd0, pending}, 32'd0);
`ifdef SSD_LZ_BLANK_EN
        set_exp(8'hFF, 8'hFF, 8'b01100011, 8'b00001101);
`else
        set_exp(8'b00000011, 8'b00000011, 8'b01100011, 8'b00001101);
`endif
        run_cycles(64);
        check_val("bnd_fd_count", fd_seen, 1);

        // Brightness: lit-anode cycles per 64-cycle frame
        bright     = 3'd0;
        low_cycles = 0;
        run_cycles(64);
        check_val("bright0_low_cycles", low_cycles, 8);
        bright     = 3'd3;
        low_cycles = 0;
        run_cycles(64);
        check_val("bright3_low_cycles", low_cycles, 32);
        bright     = 3'd7;
        low_cycles = 0;
        run_cycles(64);
        check_val("bright7_low_cycles", low_cycles, 64);

        // Reset mid-frame with a value pending
        run_cycles(10);
        drive_load(16'h9999, 4'b1111);
        check_val("pre_rst_pending", {31'd0, pending}, 32'd1);
        Reset = 1'b1;
        #1;
        check_val("midrst_an", {28'd0, an}, 32'hF);
        check_val("midrst_cath", {24'd0, cathodes}, 32'hFF);
        check_val("midrst_pending", {31'd0, pending}, 32'd0);
        check_val("midrst_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(posedge board_clk);
        #1;
        Reset   = 1'b0;
        cyc     = 0;
        fd_seen = 0;
        set_exp(8'h03, 8'h03, 8'h03, 8'h03);
        run_cycles(64);
        check_val("postrst_fd_count", fd_seen, 0);
        check_val("postrst_pending", {31'd0, pending}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
